// File: rtl/cpu24_pkg.sv
// Shared constants, fetch FSM states and the prefetch entry layout for the 24-bit CPU front end.
package cpu24_pkg;

  localparam int ADDR_W     = 24;
  localparam int INSTR_W    = 24;
  localparam int PC_STEP    = 3;
  localparam int FIFO_DEPTH = 4;
  localparam logic [ADDR_W-1:0] RESET_PC = 24'd10;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // Sequential fetch address; wraps modulo 2^ADDR_W with no flag.
  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(PC_STEP);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO with a combinational head (zero-latency pop); clear overrides push.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 48
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       din,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign count   = count_reg;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop) & ~clear;
  // Head reads as zero when empty so the consumer never sees stale words.
  assign head    = empty ? '0 : mem_reg[rd_ptr_reg];

  always_ff @(posedge Clock) begin
    if (Reset || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (do_push) mem_reg[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: PC, req/ack memory handshake, prefetch FIFO and redirect flush.
// Optional FETCH_PERF_CNT_EN adds saturating ack and redirect counters.
module instruction_fetch_unit
  import cpu24_pkg::*;
(
  input  logic               Clock,
  input  logic               Reset,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [15:0]        perf_flush_cnt
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic [ADDR_W-1:0] req_addr_reg, req_addr_next;
  logic              mem_req_raw;
  logic              handshake;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;

  always_comb begin
    mem_req_raw   = 1'b0;
    mem_addr      = fetch_pc_reg;
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    req_addr_next = req_addr_reg;

    case (state_reg)
      FETCH: begin
        mem_req_raw = (fifo_count < CNT_W'(FIFO_DEPTH));
        if (mem_req_raw && !mem_ack) begin
          state_next    = WAIT;
          req_addr_next = fetch_pc_reg;
        end
      end
      WAIT, FLUSH: begin
        // The address captured at issue is held even after a redirect moves fetch_pc.
        mem_req_raw = 1'b1;
        mem_addr    = req_addr_reg;
        if (mem_ack) state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase

    mem_req   = mem_req_raw & ~Reset;
    handshake = mem_req & mem_ack;

    if (handshake && state_reg != FLUSH) fetch_pc_next = next_pc(fetch_pc_reg);

    // A redirect that leaves a request hanging must wait out its ack in FLUSH.
    if (redirect_valid) begin
      fetch_pc_next = redirect_pc;
      state_next    = (mem_req && !mem_ack) ? FLUSH : FETCH;
    end

    push = handshake && (state_reg != FLUSH) && !redirect_valid && !fifo_full;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg    <= FETCH;
      fetch_pc_reg <= RESET_PC;
      req_addr_reg <= RESET_PC;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      req_addr_reg <= req_addr_next;
    end
  end

  assign push_entry.instr = mem_rdata;
  assign push_entry.pc    = mem_addr;
  assign pop              = instr_valid & instr_ready;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .Clock (Clock),
    .Reset (Reset),
    .push  (push),
    .pop   (pop),
    .clear (redirect_valid),
    .din   (push_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (head_entry)
  );

  assign instr_valid = ~fifo_empty;
  assign instr       = head_entry.instr;
  assign instr_pc    = head_entry.pc;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt_reg;
  logic [15:0] perf_flush_cnt_reg;

  // Acks discarded by a flush still count as memory traffic.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      perf_fetch_cnt_reg <= '0;
      perf_flush_cnt_reg <= '0;
    end else begin
      if (handshake && perf_fetch_cnt_reg != '1) perf_fetch_cnt_reg <= perf_fetch_cnt_reg + 1'b1;
      if (redirect_valid && perf_flush_cnt_reg != '1) perf_flush_cnt_reg <= perf_flush_cnt_reg + 1'b1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_cnt_reg;
  assign perf_flush_cnt = perf_flush_cnt_reg;
`else
  // Counters not built in this configuration.
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a randomized stream.
module tb_instruction_fetch_unit;
  import cpu24_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ack;
  logic [23:0] mem_rdata;
  logic        redirect_valid = 1'b0;
  logic [23:0] redirect_pc = 24'd0;
  logic        instr_valid;
  logic [23:0] instr;
  logic [23:0] instr_pc;
  logic        instr_ready = 1'b0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [15:0] perf_flush_cnt;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int mem_lat  = 0;
  int wait_cnt = 0;

  instruction_fetch_unit dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 Clock = ~Clock;

  function automatic logic [23:0] mem_word(input logic [23:0] a);
    return (a * 24'd7) ^ 24'hA5C30F;
  endfunction

  // Memory model: acks once a request has been held for mem_lat cycles.
  assign mem_ack   = mem_req && (wait_cnt >= mem_lat);
  assign mem_rdata = mem_word(mem_addr);

  always @(posedge Clock) begin
    if (Reset || !mem_req || mem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic do_reset();
    Reset = 1'b1;
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    mem_lat = 1000;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    chk_cnt++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b expected 0", mem_req); else pass_cnt++;
    chk_cnt++; if (instr_valid !== 1'b0) $display("FAIL reset_instr_valid: got %b expected 0", instr_valid); else pass_cnt++;
    chk_cnt++; if (instr !== 24'd0) $display("FAIL reset_instr: got %h expected 000000", instr); else pass_cnt++;
    chk_cnt++; if (instr_pc !== 24'd0) $display("FAIL reset_instr_pc: got %h expected 000000", instr_pc); else pass_cnt++;
    @(posedge Clock); #1 Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      chk_cnt++; if (mem_req !== 1'b1) $display("FAIL t1_mem_req: got %b expected 1", mem_req); else pass_cnt++;
      chk_cnt++; if (mem_addr !== 24'd10) $display("FAIL t1_mem_addr: got %h expected 00000a", mem_addr); else pass_cnt++;
      chk_cnt++; if (instr_valid !== 1'b0) $display("FAIL t1_no_valid: got %b expected 0", instr_valid); else pass_cnt++;
      @(posedge Clock); #1;
    end
    Reset = 1'b1;
    @(posedge Clock); #1;
    @(negedge Clock);
    chk_cnt++; if (mem_req !== 1'b0) $display("FAIL t1_reset_mid_req: got %b expected 0", mem_req); else pass_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_zero_wait();
    logic [23:0] exp_pc;
    int n;
    mem_lat = 0;
    do_reset();
    instr_ready = 1'b1;
    @(negedge Clock);
    chk_cnt++; if ((mem_req && mem_ack) !== 1'b1) $display("FAIL t2_first_ack: got %b expected 1", mem_req && mem_ack); else pass_cnt++;
    chk_cnt++; if (instr_valid !== 1'b0) $display("FAIL t2_valid_before_ack: got %b expected 0", instr_valid); else pass_cnt++;
    exp_pc = 24'd10;
    n = 0;
    for (int i = 0; i < 12 && n < 4; i++) begin
      @(posedge Clock); #1;
      @(negedge Clock);
      if (i == 0) begin
        chk_cnt++; if (instr_valid !== 1'b1) $display("FAIL t2_latency: got %b expected 1", instr_valid); else pass_cnt++;
      end
      if (instr_valid) begin
        $display("t2 pop pc=%h instr=%h", instr_pc, instr);
        chk_cnt++; if (instr_pc !== exp_pc) $display("FAIL t2_pc: got %h expected %h", instr_pc, exp_pc); else pass_cnt++;
        chk_cnt++; if (instr !== mem_word(exp_pc)) $display("FAIL t2_instr: got %h expected %h", instr, mem_word(exp_pc)); else pass_cnt++;
        exp_pc = exp_pc + 24'd3;
        n++;
      end
    end
    chk_cnt++; if (n !== 4) $display("FAIL t2_pop_count: got %0d expected 4", n); else pass_cnt++;
  endtask

  task automatic test_back_pressure();
    int n_hs;
    mem_lat = 0;
    do_reset();
    n_hs = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      if (mem_req && mem_ack) n_hs++;
      @(posedge Clock); #1;
    end
    @(negedge Clock);
    chk_cnt++; if (n_hs !== 4) $display("FAIL t3_push_count: got %0d expected 4", n_hs); else pass_cnt++;
    chk_cnt++; if (mem_req !== 1'b0) $display("FAIL t3_full_no_req: got %b expected 0", mem_req); else pass_cnt++;
    chk_cnt++; if (instr_pc !== 24'd10) $display("FAIL t3_head: got %h expected 00000a", instr_pc); else pass_cnt++;
    @(posedge Clock); #1 instr_ready = 1'b1;
    @(negedge Clock);
    $display("t3 pop pc=%h instr=%h", instr_pc, instr);
    chk_cnt++; if (mem_req !== 1'b0) $display("FAIL t3_pop_cycle_req: got %b expected 0", mem_req); else pass_cnt++;
    @(posedge Clock); #1 instr_ready = 1'b0;
    @(negedge Clock);
    chk_cnt++; if (mem_req !== 1'b1) $display("FAIL t3_refill_req: got %b expected 1", mem_req); else pass_cnt++;
    chk_cnt++; if (mem_addr !== 24'd22) $display("FAIL t3_refill_addr: got %h expected 000016", mem_addr); else pass_cnt++;
    chk_cnt++; if (instr_pc !== 24'd13) $display("FAIL t3_next_head: got %h expected 00000d", instr_pc); else pass_cnt++;
    @(posedge Clock); #1;
    @(negedge Clock);
    chk_cnt++; if (mem_req !== 1'b0) $display("FAIL t3_full_again: got %b expected 0", mem_req); else pass_cnt++;
  endtask

  task automatic test_redirect_wait();
    int seen;
    mem_lat = 3;
    do_reset();
    instr_ready = 1'b1;
    @(negedge Clock);
    chk_cnt++; if (mem_ack !== 1'b0) $display("FAIL t4_no_ack: got %b expected 0", mem_ack); else pass_cnt++;
    @(posedge Clock); #1;
    redirect_valid = 1'b1;
    redirect_pc = 24'h000100;
    @(negedge Clock);
    @(posedge Clock); #1 redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clock);
      chk_cnt++; if (mem_addr !== 24'd10) $display("FAIL t4_addr_held: got %h expected 00000a", mem_addr); else pass_cnt++;
      chk_cnt++; if (instr_valid !== 1'b0) $display("FAIL t4_stale_valid: got %b expected 0", instr_valid); else pass_cnt++;
      if (i == 1) begin
        chk_cnt++; if (mem_ack !== 1'b1) $display("FAIL t4_old_ack: got %b expected 1", mem_ack); else pass_cnt++;
      end
      @(posedge Clock); #1;
    end
    @(negedge Clock);
    chk_cnt++; if (mem_addr !== 24'h000100) $display("FAIL t4_new_addr: got %h expected 000100", mem_addr); else pass_cnt++;
    chk_cnt++; if (instr_valid !== 1'b0) $display("FAIL t4_discarded: got %b expected 0", instr_valid); else pass_cnt++;
    mem_lat = 0;
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      @(posedge Clock); #1;
      @(negedge Clock);
      if (instr_valid) begin
        seen = 1;
        $display("t4 pop pc=%h instr=%h", instr_pc, instr);
        chk_cnt++; if (instr_pc !== 24'h000100) $display("FAIL t4_first_pc: got %h expected 000100", instr_pc); else pass_cnt++;
      end
    end
    chk_cnt++; if (seen !== 1) $display("FAIL t4_timeout: got %0d expected 1", seen); else pass_cnt++;
  endtask

  task automatic test_redirect_ack();
    int seen;
    mem_lat = 0;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 24'h000200;
    @(negedge Clock);
    chk_cnt++; if ((mem_req && mem_ack) !== 1'b1) $display("FAIL t5a_ack: got %b expected 1", mem_req && mem_ack); else pass_cnt++;
    @(posedge Clock); #1;
    redirect_valid = 1'b0;
    mem_lat = 2;
    @(negedge Clock);
    chk_cnt++; if (instr_valid !== 1'b0) $display("FAIL t5a_no_push: got %b expected 0", instr_valid); else pass_cnt++;
    chk_cnt++; if (mem_addr !== 24'h000200) $display("FAIL t5a_new_addr: got %h expected 000200", mem_addr); else pass_cnt++;
    @(posedge Clock); #1;
    redirect_valid = 1'b1;
    redirect_pc = 24'h000250;
    @(negedge Clock);
    @(posedge Clock); #1;
    redirect_pc = 24'h000300;
    @(negedge Clock);
    chk_cnt++; if (mem_ack !== 1'b1) $display("FAIL t5b_ack: got %b expected 1", mem_ack); else pass_cnt++;
    chk_cnt++; if (mem_addr !== 24'h000200) $display("FAIL t5b_old_addr: got %h expected 000200", mem_addr); else pass_cnt++;
    @(posedge Clock); #1 redirect_valid = 1'b0;
    @(negedge Clock);
    chk_cnt++; if (instr_valid !== 1'b0) $display("FAIL t5b_no_push: got %b expected 0", instr_valid); else pass_cnt++;
    chk_cnt++; if ((mem_req === 1'b1 && mem_addr === 24'h000300) !== 1'b1) $display("FAIL t5b_new_req: got req=%b addr=%h expected req=1 addr=000300", mem_req, mem_addr); else pass_cnt++;
    mem_lat = 0;
    instr_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      @(posedge Clock); #1;
      @(negedge Clock);
      if (instr_valid) begin
        seen = 1;
        $display("t5 pop pc=%h instr=%h", instr_pc, instr);
        chk_cnt++; if (instr_pc !== 24'h000300) $display("FAIL t5_first_pc: got %h expected 000300", instr_pc); else pass_cnt++;
      end
    end
    chk_cnt++; if (seen !== 1) $display("FAIL t5_timeout: got %0d expected 1", seen); else pass_cnt++;
  endtask

  task automatic test_wrap();
    mem_lat = 0;
    do_reset();
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 24'hFFFFFE;
    @(negedge Clock);
    @(posedge Clock); #1 redirect_valid = 1'b0;
    @(negedge Clock);
    chk_cnt++; if (mem_addr !== 24'hFFFFFE) $display("FAIL t6_target: got %h expected fffffe", mem_addr); else pass_cnt++;
    @(posedge Clock); #1;
    @(negedge Clock);
    chk_cnt++; if (mem_addr !== 24'h000001) $display("FAIL t6_wrap_addr: got %h expected 000001", mem_addr); else pass_cnt++;
    chk_cnt++; if (instr_pc !== 24'hFFFFFE) $display("FAIL t6_head_pc: got %h expected fffffe", instr_pc); else pass_cnt++;
    chk_cnt++; if (instr !== mem_word(24'hFFFFFE)) $display("FAIL t6_head_instr: got %h expected %h", instr, mem_word(24'hFFFFFE)); else pass_cnt++;
    $display("t6 pop pc=%h instr=%h", instr_pc, instr);
`ifdef FETCH_PERF_CNT_EN
    chk_cnt++; if (perf_flush_cnt !== 16'd1) $display("FAIL t6_perf_flush: got %0d expected 1", perf_flush_cnt); else pass_cnt++;
    chk_cnt++; if (perf_fetch_cnt !== 32'd2) $display("FAIL t6_perf_fetch: got %0d expected 2", perf_fetch_cnt); else pass_cnt++;
`endif
    @(posedge Clock); #1;
    @(negedge Clock);
    chk_cnt++; if (instr_pc !== 24'h000001) $display("FAIL t6_wrap_pc: got %h expected 000001", instr_pc); else pass_cnt++;
  endtask

  task automatic test_random_stream();
    logic [23:0] exp_pc;
    logic [23:0] prev_addr;
    logic        prev_pending;
    logic        prev_redirect;
    int          n_pop;
    do_reset();
    exp_pc = RESET_PC;
    prev_addr = '0;
    prev_pending = 1'b0;
    prev_redirect = 1'b0;
    n_pop = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc != 0) begin
        @(posedge Clock); #1;
      end
      instr_ready = ($urandom_range(0, 3) != 0);
      mem_lat = $urandom_range(0, 3);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc = 24'($urandom);
      @(negedge Clock);
      if (prev_pending) begin
        chk_cnt++; if ((mem_req === 1'b1 && mem_addr === prev_addr) !== 1'b1) $display("FAIL rnd_req_held: got req=%b addr=%h expected req=1 addr=%h", mem_req, mem_addr, prev_addr); else pass_cnt++;
      end
      if (prev_redirect) begin
        chk_cnt++; if (instr_valid !== 1'b0) $display("FAIL rnd_flush_valid: got %b expected 0", instr_valid); else pass_cnt++;
      end
      if (instr_valid && instr_ready) begin
        $display("rnd pop pc=%h instr=%h", instr_pc, instr);
        chk_cnt++; if (instr_pc !== exp_pc) $display("FAIL rnd_pc: got %h expected %h", instr_pc, exp_pc); else pass_cnt++;
        chk_cnt++; if (instr !== mem_word(exp_pc)) $display("FAIL rnd_instr: got %h expected %h", instr, mem_word(exp_pc)); else pass_cnt++;
        exp_pc = exp_pc + 24'd3;
        n_pop++;
      end
      if (redirect_valid) exp_pc = redirect_pc;
      prev_pending = mem_req && !mem_ack;
      prev_addr = mem_addr;
      prev_redirect = redirect_valid;
    end
    @(posedge Clock); #1;
    redirect_valid = 1'b0;
    chk_cnt++; if (n_pop < 50) $display("FAIL rnd_progress: got %0d pops expected at least 50", n_pop); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_back_pressure();
    test_redirect_wait();
    test_redirect_ack();
    test_wrap();
    test_random_stream();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
